// File: rtl/ifns_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ifns_pkg : shared widths and Fibonacci weights for the 16-bit IFNS code
// Revision : 1.0
// ----------------------------------------------------------------------------
package ifns_pkg;

  localparam int IFNS_CW_W   = 16;
  localparam int IFNS_DATA_W = 11;
  localparam int IFNS_SUM_W  = 12;

  localparam logic [IFNS_SUM_W-1:0] IFNS_FIB_W [1:16] = '{
    12'd1,   12'd1,   12'd2,   12'd3,   12'd5,   12'd8,   12'd13,  12'd21,
    12'd34,  12'd55,  12'd89,  12'd144, 12'd233, 12'd377, 12'd610, 12'd987
  };

  // Weights of nibble group g packed with the lowest-order bit's weight in the LSBs.
  function automatic logic [4*IFNS_SUM_W-1:0] fib_group(input int g);
    fib_group = {IFNS_FIB_W[4*g+4], IFNS_FIB_W[4*g+3],
                 IFNS_FIB_W[4*g+2], IFNS_FIB_W[4*g+1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifns_nibble_sum.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ifns_nibble_sum : weighted sum of a 4-bit codeword slice (combinational)
// Revision : 1.0
// ----------------------------------------------------------------------------
module ifns_nibble_sum
  import ifns_pkg::*;
(
  input  logic [3:0]              i_slice,
  input  logic [4*IFNS_SUM_W-1:0] i_weights,
  output logic [IFNS_SUM_W-1:0]   o_sum
);

  always_comb begin
    o_sum = '0;
    for (int j = 0; j < 4; j++) begin
      if (i_slice[j]) begin
        o_sum = o_sum + i_weights[j*IFNS_SUM_W +: IFNS_SUM_W];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ifns_decoder_16.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ifns_decoder_16 : 3-stage IFNS codeword decoder with range flag and error count
// Revision : 1.0
// ----------------------------------------------------------------------------
module ifns_decoder_16
  import ifns_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic [IFNS_CW_W-1:0]   codein,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [IFNS_DATA_W-1:0] dataout,
  output logic                   range_err,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   err_clr,
  output logic [ERR_CNT_W-1:0]   err_count
);

  logic                  w_adv;
  logic [IFNS_CW_W-1:0]  r_s1_cw;
  logic                  r_s1_vld;
  logic [IFNS_SUM_W-1:0] w_psum   [4];
  logic [IFNS_SUM_W-1:0] r_s2_psum [4];
  logic                  r_s2_vld;
  logic [IFNS_SUM_W-1:0] w_total;
  logic                  w_consume;

  assign w_adv     = !out_valid || out_ready;
  assign in_ready  = w_adv;
  assign w_consume = out_valid && out_ready;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_nib
      localparam logic [4*IFNS_SUM_W-1:0] c_weights = fib_group(g);
      ifns_nibble_sum u_nibble_sum (
        .i_slice   (r_s1_cw[4*g +: 4]),
        .i_weights (c_weights),
        .o_sum     (w_psum[g])
      );
    end
  endgenerate

  // Maximum total is 2583, so a 12-bit add cannot overflow.
  assign w_total = r_s2_psum[0] + r_s2_psum[1] + r_s2_psum[2] + r_s2_psum[3];

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_s1_cw   <= '0;
      r_s1_vld  <= 1'b0;
      r_s2_psum <= '{default: '0};
      r_s2_vld  <= 1'b0;
      dataout   <= '0;
      range_err <= 1'b0;
      out_valid <= 1'b0;
    end else if (w_adv) begin
      r_s1_cw   <= codein;
      r_s1_vld  <= in_valid;
      r_s2_psum <= w_psum;
      r_s2_vld  <= r_s1_vld;
      out_valid <= r_s2_vld;
      // Output data only moves with a real word so bubbles leave it untouched.
      if (r_s2_vld) begin
        dataout   <= w_total[IFNS_DATA_W-1:0];
        range_err <= w_total[IFNS_SUM_W-1];
      end
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (w_consume && range_err && !(&err_count)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifns_decoder_16.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ifns_decoder_16 : directed vector bench for ifns_decoder_16
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_ifns_decoder_16;

  typedef struct packed {
    logic [15:0] cw;
    logic [10:0] data;
    logic        err;
  } vec_t;

  logic        clock = 1'b0;
  logic        rst   = 1'b1;
  logic [15:0] codein   = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] dataout;
  logic        range_err;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        err_clr   = 1'b0;
  logic [1:0]  err_count;

  always #5 clock = ~clock;

  ifns_decoder_16 #(.ERR_CNT_W(2)) dut (
    .clock     (clock),
    .rst       (rst),
    .codein    (codein),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dataout   (dataout),
    .range_err (range_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_clr   (err_clr),
    .err_count (err_count)
  );

  vec_t exp_q[$];
  vec_t cur;
  int   n_vec  = 0;
  int   n_bad  = 0;
  int   n_cons = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    cur      = v;
    codein   = v.cw;
    in_valid = 1'b1;
  endtask

  // One clock: log accepted inputs, check consumed outputs, then advance.
  task automatic step();
    vec_t e;
    #1;
    if (in_valid && in_ready) exp_q.push_back(cur);
    if (out_valid && out_ready) begin
      n_cons++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_output: got dataout %0d, expected no output", dataout);
      end else begin
        e = exp_q.pop_front();
        chk("dataout", 32'(dataout), 32'(e.data));
        chk("range_err", 32'(range_err), 32'(e.err));
      end
    end
    @(posedge clock);
    #1;
  endtask

  vec_t tbl [6];
  vec_t sv  [5];
  vec_t v_one, v_ff;

  initial begin
    int idx, stalls, c0, cyc;
    tbl[0] = '{cw: 16'h0000, data: 11'd0,    err: 1'b0};
    tbl[1] = '{cw: 16'h0004, data: 11'd2,    err: 1'b0};
    tbl[2] = '{cw: 16'h8000, data: 11'd987,  err: 1'b0};
    tbl[3] = '{cw: 16'hE250, data: 11'd2047, err: 1'b0};
    tbl[4] = '{cw: 16'hE251, data: 11'd0,    err: 1'b1};
    tbl[5] = '{cw: 16'hFFFF, data: 11'd535,  err: 1'b1};
    sv[0]  = '{cw: 16'h0002, data: 11'd1,    err: 1'b0};
    sv[1]  = '{cw: 16'h0008, data: 11'd3,    err: 1'b0};
    sv[2]  = '{cw: 16'h0010, data: 11'd5,    err: 1'b0};
    sv[3]  = '{cw: 16'h0100, data: 11'd34,   err: 1'b0};
    sv[4]  = '{cw: 16'h1000, data: 11'd233,  err: 1'b0};
    v_one  = '{cw: 16'h0001, data: 11'd1,    err: 1'b0};
    v_ff   = '{cw: 16'hFFFF, data: 11'd535,  err: 1'b1};

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_dataout", 32'(dataout), 0);
    chk("rst_range_err", 32'(range_err), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst = 1'b0;
    @(posedge clock);
    #1;

    // Single word latency: valid after the third edge, for one cycle only
    out_ready = 1'b1;
    drive(v_one);
    step();
    in_valid = 1'b0;
    step();
    chk("lat_early_valid", 32'(out_valid), 0);
    step();
    chk("lat_valid", 32'(out_valid), 1);
    chk("lat_data", 32'(dataout), 1);
    step();
    chk("lat_one_cycle", 32'(out_valid), 0);

    // Back-to-back table stream, including both range-error boundaries
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i]);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    chk("stream_drained", exp_q.size(), 0);
    chk("stream_err_count", 32'(err_count), 2);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_err_count", 32'(err_count), 0);

    // Output stall of 4 cycles after the first word of a 5-word stream
    idx = 0; stalls = 0; c0 = n_cons;
    for (cyc = 0; cyc < 40 && !(idx == 5 && exp_q.size() == 0); cyc++) begin
      if (idx < 5) drive(sv[idx]);
      else in_valid = 1'b0;
      if ((n_cons - c0) == 1 && stalls < 4) begin
        out_ready = 1'b0;
        stalls++;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (!out_ready) chk("stall_in_ready", 32'(in_ready), 0);
      if (in_valid && in_ready) idx++;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stall_all_out", 32'(idx == 5 && exp_q.size() == 0), 1);
    chk("stall_count", n_cons - c0, 5);

    // Reset with three words in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(v_ff);
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    exp_q.delete();
    @(posedge clock);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("no_stale", 32'(out_valid), 0);
    end
    chk("rst_err_cnt", 32'(err_count), 0);

    // Saturation of a 2-bit counter, then clear beating an increment
    for (int i = 0; i < 4; i++) begin
      drive(v_ff);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    chk("sat_err_count", 32'(err_count), 3);
    drive(v_ff);
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("clrwin_valid", 32'(out_valid), 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clrwin_err_count", 32'(err_count), 0);
    chk("final_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
